ram_hs_arbiter: RTL and testbench
=================================

Name: ram_hs_arbiter

Overview:
- Shares one handshake RAM wrapper (AXI-lite-style aw/ar/r channels, 1-cycle read latency, at most one response pending) between NUM_RD read requesters and NUM_WR write requesters.
- Each port group has round-robin arbitration with a bounded burst lock.
- Read responses are routed back to the issuing requester through an in-order ID queue.
- Same-cycle same-address read/write hazards are resolved by stalling the read.
- Sits between PE-side buffer clients and a single on-chip SRAM bank.

Parameters:
NUM_RD, 4, number of read requesters (>=1)
NUM_WR, 2, number of write requesters (>=1)
ADDR_W, 6, SRAM word address width
DATA_W, 128, SRAM word width
MAX_BURST, 4, max consecutive grants held by one requester (>=1)
ID_W, $clog2(NUM_RD) (min 1), read ID width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rd_arvalid  in  NUM_RD  per-requester read request
rd_arready  out  NUM_RD  per-requester read accept
rd_araddr  in  NUM_RD*ADDR_W  packed read addresses, requester i at [i*ADDR_W +: ADDR_W]
rd_rvalid  out  NUM_RD  per-requester read data valid (one-hot or zero)
rd_rready  in  NUM_RD  per-requester read data ready
rd_rdata  out  DATA_W  read data, broadcast to all requesters
wr_wvalid  in  NUM_WR  per-requester write request
wr_wready  out  NUM_WR  per-requester write accept
wr_waddr  in  NUM_WR*ADDR_W  packed write addresses
wr_wdata  in  NUM_WR*DATA_W  packed write data
m_arvalid, m_arready(in), m_araddr  -  1/1/ADDR_W  to RAM read-address channel
m_rvalid(in), m_rready, m_rdata(in)  -  1/1/DATA_W  from RAM read-data channel
m_wvalid, m_wready(in), m_waddr, m_wdata  -  1/1/ADDR_W/DATA_W  to RAM write channel

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk. With rst=1 at an edge, all registers return to reset values.
- Reset values:
  - rr_ptr_rd = 0, rr_ptr_wr = 0
  - burst counters = 0, lock owners invalid
  - ID queue empty
  - In reset, all outputs read 0 (m_* valids, rd_arready, wr_wready, rd_rvalid, m_rready).
- Write grant (combinational):
  - If the lock is held and the owner's wvalid=1, grant the owner.
  - Otherwise grant the first requester with wvalid=1, searching from rr_ptr_wr upward with wrap.
  - m_wvalid = granted valid; m_waddr/m_wdata are muxed from the winner.
  - wr_wready[g] = m_wready & grant[g]. All other wready are 0.
- Write burst lock, on an accepted beat (m_wvalid & m_wready):
  - If the winner equals the owner, cnt++; else owner := winner, cnt := 1.
  - When cnt reaches MAX_BURST, or the owner drops valid: release the lock, set rr_ptr_wr := owner+1 mod NUM_WR, set cnt := 0.
  - If no beat is accepted and the owner's valid is low, the lock is released the same way.
- Read grant: same rule applied to rd_arvalid with rr_ptr_rd and a separate lock/counter, with two extra gates:
  - m_arvalid is forced 0 when the ID queue is full.
  - m_arvalid is forced 0 on a hazard: m_wvalid & m_wready & (m_waddr == winner's araddr). The read waits one cycle so it returns new data.
  - rd_arready[g] = m_arvalid & m_arready & grant[g].
- ID queue:
  - Depth 2 FIFO of ID_W.
  - Push the winner ID on m_arvalid & m_arready. Pop on m_rvalid & m_rready.
  - Simultaneous push+pop is allowed at any occupancy and leaves the count unchanged.
  - Full = 2 entries. An overflow or underflow attempt is a design error; the bench asserts it never happens.
- Response routing:
  - head = queue head ID.
  - rd_rvalid[head] = m_rvalid & !empty; all other bits 0.
  - m_rready = rd_rready[head] & !empty.
  - rd_rdata = m_rdata.
  - m_rvalid while the queue is empty is an error and is ignored (m_rready=0).
- Ordering: responses are returned strictly in issue order. Each requester sees its own reads in order.
- Latency: a grant is combinational (0 extra cycles). The arbiter adds no pipeline stage. Read data arrives 1 cycle after acceptance, per the RAM wrapper.
- Reset mid-operation: the queue is flushed and pending responses are dropped. Requesters must reissue.

Test Plan:
1. Single read: rd_arvalid=4'b0100, addr 5, RAM preloaded with word 5 = 0xAB -> rd_arready[2]=1 in cycle 0; rd_rvalid=4'b0100 with rd_rdata=0xAB in cycle 1; the queue returns to empty.
2. Round robin with MAX_BURST=2: all 4 read requesters hold valid continuously, rd_rready=all 1 -> acceptance order 0,0,1,1,2,2,3,3,0,0; rd_rvalid follows the same order one cycle later.
3. Backpressure: requester 1 reads, then holds rd_rready[1]=0 for 3 cycles while requester 2 requests -> requester 2 is accepted once (queue depth 2), then m_arvalid=0 until the pop; data is delivered 1 then 2 with correct values.
4. Hazard: wr requester 0 writes 0x55 to addr 9 while rd requester 3 reads addr 9 in the same cycle -> read is stalled 1 cycle, then returns 0x55. A different address in the same cycle is not stalled.
5. Write arbitration: both writers hold valid with m_wready toggling 1,0,1,1 -> lock survives the wready=0 cycle; the burst counter counts only accepted beats; grant switches after 4 accepted beats.
6. Reset mid-read: rst=1 for one cycle while 2 reads are outstanding -> next cycle queue empty, rd_rvalid=0, rr pointers 0; requester 0 wins the next contention.

Source files
------------

// File: rtl/ram_hs_arbiter.sv
// ---------------------------------------------------------------------------
// ram_hs_arbiter: RR + burst-locked read/write arbitration onto one handshake RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_hs_rr_lock #(
  parameter int N         = 2,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             accept_i,
  output logic             gnt_vld_o,
  output logic [IDX_W-1:0] gnt_idx_o
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic             lock_q, lock_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   w_req_dbl;
  logic [N-1:0]     w_req_rot;
  logic [IDX_W:0]   w_sum;
  logic             w_owner_req;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  assign w_owner_req = req_i[owner_q];
  assign w_req_dbl   = {req_i, req_i};
  assign w_req_rot   = w_req_dbl[ptr_q +: N];

  always_comb begin
    w_sum     = '0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    if (lock_q && w_owner_req) begin
      gnt_vld_o = 1'b1;
      gnt_idx_o = owner_q;
    end else begin
      // Descending scan so the requester closest to ptr_q is the last (winning) hit.
      for (int k = N - 1; k >= 0; k--) begin
        if (w_req_rot[k]) begin
          gnt_vld_o = 1'b1;
          w_sum     = {1'b0, ptr_q} + (IDX_W+1)'(k);
        end
      end
      if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
      gnt_idx_o = w_sum[IDX_W-1:0];
    end
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (accept_i) begin
      if (lock_q && (gnt_idx_o == owner_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        lock_d  = 1'b1;
        owner_d = gnt_idx_o;
        cnt_d   = CNT_W'(1);
      end
      if (cnt_d == CNT_W'(MAX_BURST)) begin
        lock_d = 1'b0;
        cnt_d  = '0;
        ptr_d  = wrap_inc(owner_d);
      end
    end else if (lock_q && !w_owner_req) begin
      lock_d = 1'b0;
      cnt_d  = '0;
      ptr_d  = wrap_inc(owner_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module ram_hs_arbiter #(
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_arvalid_i,
  output logic [NUM_RD-1:0]        rd_arready_o,
  input  logic [NUM_RD*ADDR_W-1:0] rd_araddr_i,
  output logic [NUM_RD-1:0]        rd_rvalid_o,
  input  logic [NUM_RD-1:0]        rd_rready_i,
  output logic [DATA_W-1:0]        rd_rdata_o,
  input  logic [NUM_WR-1:0]        wr_wvalid_i,
  output logic [NUM_WR-1:0]        wr_wready_o,
  input  logic [NUM_WR*ADDR_W-1:0] wr_waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_wdata_i,
  output logic                     m_arvalid_o,
  input  logic                     m_arready_i,
  output logic [ADDR_W-1:0]        m_araddr_o,
  input  logic                     m_rvalid_i,
  output logic                     m_rready_o,
  input  logic [DATA_W-1:0]        m_rdata_i,
  output logic                     m_wvalid_o,
  input  logic                     m_wready_i,
  output logic [ADDR_W-1:0]        m_waddr_o,
  output logic [DATA_W-1:0]        m_wdata_o
);
  localparam int WID_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [ADDR_W-1:0] w_araddr_arr [NUM_RD];
  logic [ADDR_W-1:0] w_waddr_arr  [NUM_WR];
  logic [DATA_W-1:0] w_wdata_arr  [NUM_WR];

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd_unpack
      assign w_araddr_arr[g] = rd_araddr_i[g*ADDR_W +: ADDR_W];
    end
    for (g = 0; g < NUM_WR; g++) begin : g_wr_unpack
      assign w_waddr_arr[g] = wr_waddr_i[g*ADDR_W +: ADDR_W];
      assign w_wdata_arr[g] = wr_wdata_i[g*DATA_W +: DATA_W];
    end
  endgenerate

  logic             w_wr_vld, w_rd_vld;
  logic [WID_W-1:0] w_wr_idx;
  logic [ID_W-1:0]  w_rd_idx;
  logic             w_wbeat, w_rbeat, w_hazard, w_arvalid;
  logic             w_push, w_pop, w_empty, w_full;
  logic [ID_W-1:0]  w_head;

  logic [ID_W-1:0]  idq_q [2];
  logic             idq_wr_q, idq_rd_q;
  logic [1:0]       idq_cnt_q;

  ram_hs_rr_lock #(.N(NUM_WR), .MAX_BURST(MAX_BURST), .IDX_W(WID_W)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (wr_wvalid_i),
    .accept_i  (w_wbeat),
    .gnt_vld_o (w_wr_vld),
    .gnt_idx_o (w_wr_idx)
  );

  ram_hs_rr_lock #(.N(NUM_RD), .MAX_BURST(MAX_BURST), .IDX_W(ID_W)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (rd_arvalid_i),
    .accept_i  (w_rbeat),
    .gnt_vld_o (w_rd_vld),
    .gnt_idx_o (w_rd_idx)
  );

  assign w_wbeat    = m_wvalid_o & m_wready_i;
  // A read colliding with a write landing this cycle waits so it observes the new word.
  assign w_hazard   = w_wbeat & (w_waddr_arr[w_wr_idx] == w_araddr_arr[w_rd_idx]);
  assign w_empty    = (idq_cnt_q == 2'd0);
  assign w_full     = (idq_cnt_q == 2'd2);
  assign w_arvalid  = w_rd_vld & ~w_full & ~w_hazard;
  assign w_rbeat    = m_arvalid_o & m_arready_i;
  assign w_head     = idq_q[idq_rd_q];
  assign w_push     = w_rbeat;
  assign w_pop      = m_rvalid_i & m_rready_o;

  assign m_wvalid_o   = ~rst & w_wr_vld;
  assign m_waddr_o    = rst ? '0 : w_waddr_arr[w_wr_idx];
  assign m_wdata_o    = rst ? '0 : w_wdata_arr[w_wr_idx];
  assign wr_wready_o  = (m_wvalid_o & m_wready_i) ? (NUM_WR'(1) << w_wr_idx) : '0;

  assign m_arvalid_o  = ~rst & w_arvalid;
  assign m_araddr_o   = rst ? '0 : w_araddr_arr[w_rd_idx];
  assign rd_arready_o = w_rbeat ? (NUM_RD'(1) << w_rd_idx) : '0;

  assign rd_rvalid_o  = (~rst & m_rvalid_i & ~w_empty) ? (NUM_RD'(1) << w_head) : '0;
  assign m_rready_o   = ~rst & ~w_empty & rd_rready_i[w_head];
  assign rd_rdata_o   = rst ? '0 : m_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      idq_q[0]  <= '0;
      idq_q[1]  <= '0;
      idq_wr_q  <= 1'b0;
      idq_rd_q  <= 1'b0;
      idq_cnt_q <= 2'd0;
    end else begin
      if (w_push) begin
        idq_q[idq_wr_q] <= w_rd_idx;
        idq_wr_q        <= ~idq_wr_q;
      end
      if (w_pop) idq_rd_q <= ~idq_rd_q;
      case ({w_push, w_pop})
        2'b10:   idq_cnt_q <= idq_cnt_q + 2'd1;
        2'b01:   idq_cnt_q <= idq_cnt_q - 2'd1;
        default: idq_cnt_q <= idq_cnt_q;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_ram_hs_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_hs_arbiter: randomized bench with a queue-based reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_hs_arbiter;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int MB  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NRD-1:0]    rd_arvalid, rd_arready, rd_rvalid, rd_rready;
  logic [NRD*AW-1:0] rd_araddr;
  logic [DW-1:0]     rd_rdata;
  logic [NWR-1:0]    wr_wvalid, wr_wready;
  logic [NWR*AW-1:0] wr_waddr;
  logic [NWR*DW-1:0] wr_wdata;
  logic              m_arvalid, m_arready, m_rvalid, m_rready, m_wvalid, m_wready;
  logic [AW-1:0]     m_araddr, m_waddr;
  logic [DW-1:0]     m_rdata, m_wdata;

  always #5 clk = ~clk;

  ram_hs_arbiter #(.NUM_RD(NRD), .NUM_WR(NWR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .rd_arvalid_i(rd_arvalid), .rd_arready_o(rd_arready), .rd_araddr_i(rd_araddr),
    .rd_rvalid_o(rd_rvalid), .rd_rready_i(rd_rready), .rd_rdata_o(rd_rdata),
    .wr_wvalid_i(wr_wvalid), .wr_wready_o(wr_wready), .wr_waddr_i(wr_waddr), .wr_wdata_i(wr_wdata),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_waddr_o(m_waddr), .m_wdata_o(m_wdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration state, kept as plain integers.
  int rlk, rown, rcnt, rptr, wlk, wown, wcnt, wptr;
  int            idq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] refmem [64];
  logic [DW-1:0] envmem [64];
  logic [DW-1:0] envq[$];

  function automatic int pick(input logic [7:0] v, input int n, input int lk, input int own, input int ptr);
    if (lk != 0 && v[own]) return own;
    for (int k = 0; k < n; k++) if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic arb_upd(input int gi, input bit beat, input bit ownv, input int n,
                         inout int lk, inout int own, inout int cnt, inout int ptr);
    if (beat) begin
      if (lk != 0 && gi == own) cnt++;
      else begin lk = 1; own = gi; cnt = 1; end
      if (cnt == MB) begin lk = 0; cnt = 0; ptr = (own + 1) % n; end
    end else if (lk != 0 && !ownv) begin
      lk = 0; cnt = 0; ptr = (own + 1) % n;
    end
  endtask

  task automatic model_reset();
    rlk = 0; rown = 0; rcnt = 0; rptr = 0;
    wlk = 0; wown = 0; wcnt = 0; wptr = 0;
    idq.delete(); dq.delete(); envq.delete();
  endtask

  task automatic drive(input int ph);
    int amax;
    amax = (ph == 2) ? 3 : 7;
    rd_arvalid = (ph == 1) ? '1 : NRD'($urandom);
    wr_wvalid  = (ph == 1) ? '0 : (ph == 2) ? '1 : NWR'($urandom);
    m_wready   = (ph == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int i = 0; i < NRD; i++) begin
      rd_araddr[i*AW +: AW] = AW'($urandom_range(0, amax));
      rd_rready[i] = (ph == 1) ? 1'b1 : (ph == 3) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < NWR; i++) begin
      wr_waddr[i*AW +: AW] = AW'($urandom_range(0, amax));
      wr_wdata[i*DW +: DW] = $urandom;
    end
    m_arready = (envq.size() < 2) && (ph == 1 || $urandom_range(0, 3) != 0);
    m_rvalid  = (envq.size() > 0);
    m_rdata   = (envq.size() > 0) ? envq[0] : '0;
  endtask

  initial begin
    int wg, rg, ph, hid;
    bit wbeat, rbeat, hz, earv, emrr, a_rbeat, a_pop, a_wbeat;
    logic [AW-1:0] a_raddr, a_waddr;
    logic [DW-1:0] a_wdata;
    logic [NRD-1:0] erv;

    for (int i = 0; i < 64; i++) begin
      refmem[i] = $urandom;
      envmem[i] = refmem[i];
    end
    model_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0);
      #1;
      chk("rst_valids", {m_arvalid, m_wvalid, m_rready, rd_arready, rd_rvalid, wr_wready}, '0);
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      ph = (cyc / 500) % 4;
      @(negedge clk);
      rst = (cyc == 1234 || cyc == 2750);
      drive(ph);
      #1;
      a_rbeat = m_arvalid & m_arready; a_raddr = m_araddr;
      a_pop   = m_rvalid & m_rready;
      a_wbeat = m_wvalid & m_wready;   a_waddr = m_waddr; a_wdata = m_wdata;
      wg = -1; rg = -1; wbeat = 0; rbeat = 0; emrr = 0;
      if (rst) begin
        chk("rst_mid", {m_arvalid, m_wvalid, m_rready, rd_arready, rd_rvalid, wr_wready}, '0);
      end else begin
        wg = pick(8'(wr_wvalid), NWR, wlk, wown, wptr);
        rg = pick(8'(rd_arvalid), NRD, rlk, rown, rptr);
        wbeat = (wg >= 0) && m_wready;
        hz    = wbeat && rg >= 0 && (wr_waddr[wg*AW +: AW] == rd_araddr[rg*AW +: AW]);
        earv  = (rg >= 0) && (idq.size() < 2) && !hz;
        rbeat = earv && m_arready;
        hid   = (idq.size() > 0) ? idq[0] : 0;
        erv   = (m_rvalid && idq.size() > 0) ? NRD'(1) << hid : '0;
        emrr  = (idq.size() > 0) && rd_rready[hid];
        chk("m_wvalid", m_wvalid, wg >= 0);
        chk("wr_wready", wr_wready, wbeat ? NWR'(1) << wg : '0);
        if (wg >= 0) begin
          chk("m_waddr", m_waddr, wr_waddr[wg*AW +: AW]);
          chk("m_wdata", m_wdata, wr_wdata[wg*DW +: DW]);
        end
        chk("m_arvalid", m_arvalid, earv);
        chk("rd_arready", rd_arready, rbeat ? NRD'(1) << rg : '0);
        if (earv) chk("m_araddr", m_araddr, rd_araddr[rg*AW +: AW]);
        chk("rd_rvalid", rd_rvalid, erv);
        chk("m_rready", m_rready, emrr);
        if (m_rvalid && emrr) chk("rd_rdata", rd_rdata, dq[0]);
      end

      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        if (a_pop && envq.size() > 0) void'(envq.pop_front());
        if (a_rbeat) envq.push_back(envmem[a_raddr]);
        if (a_wbeat) envmem[a_waddr] = a_wdata;
        if (m_rvalid && emrr) begin
          void'(idq.pop_front());
          void'(dq.pop_front());
        end
        if (rbeat) begin
          idq.push_back(rg);
          dq.push_back(refmem[rd_araddr[rg*AW +: AW]]);
        end
        if (wbeat) refmem[wr_waddr[wg*AW +: AW]] = wr_wdata[wg*DW +: DW];
        arb_upd(wg, wbeat, wr_wvalid[wown], NWR, wlk, wown, wcnt, wptr);
        arb_upd(rg, rbeat, rd_arvalid[rown], NRD, rlk, rown, rcnt, rptr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
